// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen
//   Parametrised stand-in for a camera sensor. Produces a UYVY byte stream
//   with HREF/VSYNC framing for an arbitrary frame geometry, a choice of
//   test patterns, a frame counter and a frame-start pulse. A run request
//   that drops mid-frame lets the current frame finish before going idle.
//
// Ports
//   PCLK         in   pixel clock, all logic on the rising edge
//   RST          in   synchronous reset, active high
//   ENABLE       in   run request, sampled every cycle
//   MODE[1:0]    in   00 incrementing, 01 colour bars, 10 flat grey, 11 frame-number fill
//   HREF         out  line valid, high during active bytes
//   VSYNC        out  vertical sync, active high, whole lines
//   CAMDATA[7:0] out  UYVY byte stream, 0x00 while HREF is low
//   FRAME_START  out  one-cycle pulse at the start of every frame
//   FRAME_CNT    out  frames started since reset, wraps at 16 bits
//   BUSY         out  high while a frame is in progress
module camera_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 320,
  parameter int V_ACTIVE = 480,
  parameter int VFP      = 8,
  parameter int VPW      = 4,
  parameter int VBP      = 8
) (
  input  logic        PCLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [1:0]  MODE,
  output logic        HREF,
  output logic        VSYNC,
  output logic [7:0]  CAMDATA,
  output logic        FRAME_START,
  output logic [15:0] FRAME_CNT,
  output logic        BUSY
);

  localparam int HB       = 2 * H_ACTIVE;
  localparam int HTOTAL   = HB + H_BLANK;
  localparam int V_FIRST  = VFP + VPW + VBP;
  localparam int VTOTAL   = V_FIRST + V_ACTIVE;
  localparam int BAR_W    = H_ACTIVE / 4;
  localparam int HW       = (HTOTAL > 1) ? $clog2(HTOTAL) : 1;
  localparam int VW       = (VTOTAL > 1) ? $clog2(VTOTAL) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(HB - 1);
  localparam logic [HW-1:0] BAR_DIV    = HW'(BAR_W);
  localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT_FST  = VW'(V_FIRST);
  localparam logic [VW-1:0] VS_FIRST   = VW'(VFP);
  localparam logic [VW-1:0] VS_LAST    = VW'(VFP + VPW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // BT.601 100% colour bars, white..black
  function automatic logic [7:0] bar_y(input logic [2:0] idx);
    case (idx)
      3'd0: bar_y = 8'hEB;
      3'd1: bar_y = 8'hD2;
      3'd2: bar_y = 8'hAA;
      3'd3: bar_y = 8'h91;
      3'd4: bar_y = 8'h6A;
      3'd5: bar_y = 8'h51;
      3'd6: bar_y = 8'h29;
      default: bar_y = 8'h10;
    endcase
  endfunction

  function automatic logic [7:0] bar_u(input logic [2:0] idx);
    case (idx)
      3'd0: bar_u = 8'h80;
      3'd1: bar_u = 8'h10;
      3'd2: bar_u = 8'hA6;
      3'd3: bar_u = 8'h36;
      3'd4: bar_u = 8'hCA;
      3'd5: bar_u = 8'h5A;
      3'd6: bar_u = 8'hF0;
      default: bar_u = 8'h80;
    endcase
  endfunction

  function automatic logic [7:0] bar_v(input logic [2:0] idx);
    case (idx)
      3'd0: bar_v = 8'h80;
      3'd1: bar_v = 8'h92;
      3'd2: bar_v = 8'h10;
      3'd3: bar_v = 8'h22;
      3'd4: bar_v = 8'hDE;
      3'd5: bar_v = 8'hF0;
      3'd6: bar_v = 8'h6E;
      default: bar_v = 8'h80;
    endcase
  endfunction

  state_t        state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [VW-1:0] vcnt, vcnt_nxt;
  logic [1:0]    mode_q;
  logic [7:0]    incr_q;

  // Stage p0: counter state of the current cycle decoded into next outputs
  logic          vld_p0;
  logic          first_p0;
  logic          href_p0;
  logic          vsync_p0;
  logic [1:0]    mode_p0;
  logic [7:0]    fill_p0;
  logic [2:0]    bar_p0;
  logic [7:0]    data_p0;

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = '0;
    vcnt_nxt  = '0;
    case (state)
      IDLE: begin
        if (ENABLE) state_nxt = RUN;
      end
      RUN, STOP: begin
        if (hcnt == H_LAST) begin
          hcnt_nxt = '0;
          vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
          vcnt_nxt = vcnt;
        end
        // A stop request only takes effect once the frame is complete
        if (hcnt == H_LAST && vcnt == V_LAST)
          state_nxt = ENABLE ? RUN : IDLE;
        else
          state_nxt = ENABLE ? RUN : STOP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vld_p0   = (state != IDLE);
    first_p0 = vld_p0 && (hcnt == '0) && (vcnt == '0);
    // Mode and fill value are latched at frame start; bypass on the first
    // cycle so the new frame uses them immediately
    mode_p0  = first_p0 ? MODE : mode_q;
    fill_p0  = first_p0 ? (FRAME_CNT[7:0] + 8'd1) : FRAME_CNT[7:0];
    href_p0  = vld_p0 && (vcnt >= V_ACT_FST) && (hcnt <= H_ACT_LAST);
    vsync_p0 = vld_p0 && (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
    bar_p0   = 3'(hcnt / BAR_DIV);
    data_p0  = 8'h00;
    if (href_p0) begin
      case (mode_p0)
        2'b00: data_p0 = incr_q;
        2'b01: begin
          case (hcnt[1:0])
            2'd0:    data_p0 = bar_u(bar_p0);
            2'd2:    data_p0 = bar_v(bar_p0);
            default: data_p0 = bar_y(bar_p0);
          endcase
        end
        2'b10:   data_p0 = 8'h80;
        default: data_p0 = fill_p0;
      endcase
    end
  end

  // Stage p1: registered outputs, one cycle behind the counters
  always_ff @(posedge PCLK) begin
    if (RST) begin
      state       <= IDLE;
      hcnt        <= '0;
      vcnt        <= '0;
      mode_q      <= 2'b00;
      incr_q      <= 8'h00;
      HREF        <= 1'b0;
      VSYNC       <= 1'b0;
      CAMDATA     <= 8'h00;
      FRAME_START <= 1'b0;
      FRAME_CNT   <= 16'h0000;
      BUSY        <= 1'b0;
    end else begin
      state       <= state_nxt;
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      HREF        <= href_p0;
      VSYNC       <= vsync_p0;
      CAMDATA     <= data_p0;
      FRAME_START <= first_p0;
      BUSY        <= vld_p0;
      if (first_p0) begin
        FRAME_CNT <= FRAME_CNT + 16'd1;
        mode_q    <= MODE;
      end
      if (href_p0 && mode_p0 == 2'b00)
        incr_q <= incr_q + 8'd1;
    end
  end

endmodule
